laser_pulse_rx: RTL

Receiver end of the laser timer link. Samples the laser drive or sensed beam line `d` and measures the length of each high run. It flags runs of exactly PULSE_LEN cycles as valid shots and any other length as errors. It keeps a saturating count of valid shots for status readout.

---
 rtl/laser_pulse_rx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/laser_pulse_rx.sv
// laser_pulse_rx
// Receiver end of the laser timer link. Measures the length of every high run
// on the laser line and reports each finished run as either a valid shot
// (exactly PULSE_LEN high samples) or an error (any other length). A
// saturating counter tracks valid shots for status readout.
//
// Parameters:
//   PULSE_LEN  required high-run length in clk cycles (>= 1)
//   CNT_W      width of the valid-shot counter
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   d      in   laser line
//   clr    in   synchronous clear of count (wins over an increment)
//   valid  out  one-cycle pulse, a run of exactly PULSE_LEN ended
//   err    out  one-cycle pulse, a run of the wrong length ended
//   busy   out  high while a run is being measured
//   count  out  saturating number of valid shots
//
// Build option:
//   LASER_RX_SYNC_EN  when defined, d passes through a 2-flop synchronizer
//                     (reset to 0) so it may be asynchronous; all detection
//                     latencies grow by 2 cycles.

module laser_pulse_rx #(
    parameter int PULSE_LEN = 3,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d,
    input  logic             clr,
    output logic             valid,
    output logic             err,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    localparam int WW = $clog2(PULSE_LEN + 2);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LONG = 2'd2;

    localparam logic [WW-1:0]    PULSE_W = WW'(PULSE_LEN);
    localparam logic [WW-1:0]    LONG_W  = WW'(PULSE_LEN + 1);
    localparam logic [WW-1:0]    ONE_W   = WW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             dSample;
    logic [1:0]       state_q, state_d;
    logic [WW-1:0]    width_q, width_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] count_q, count_d;

`ifdef LASER_RX_SYNC_EN
    logic sync1_q, sync2_q;

    // Two-flop synchronizer; run lengths are preserved, only delayed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= d;
            sync2_q <= sync1_q;
        end
    end

    assign dSample = sync2_q;
`else
    assign dSample = d;
`endif

    // Run-length FSM. The edge that samples the terminating 0 returns to IDLE
    // and reports the run, so a single low sample between runs is enough.
    // LONG holds width at PULSE_LEN+1 so the counter never grows further.
    always_comb begin
        state_d = state_q;
        width_d = width_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (dSample) begin
                    state_d = HIGH;
                    width_d = ONE_W;
                end
            end
            HIGH: begin
                if (dSample) begin
                    if (width_q < PULSE_W) begin
                        width_d = width_q + ONE_W;
                    end else begin
                        state_d = LONG;
                        width_d = LONG_W;
                    end
                end else begin
                    state_d = IDLE;
                    width_d = '0;
                    if (width_q == PULSE_W) begin
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LONG: begin
                if (!dSample) begin
                    state_d = IDLE;
                    width_d = '0;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                width_d = '0;
            end
        endcase
    end

    // Shot counter: clr beats a same-cycle increment, and the count sticks
    // at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (valid_d && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end
    end

    // Reset is asynchronous so a partial run is dropped without any report.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            width_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            width_q <= width_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign valid = valid_q;
    assign err   = err_q;
    assign busy  = (state_q != IDLE);
    assign count = count_q;

endmodule
